uart_tx_serialiser: RTL and testbench
=====================================

Name: uart_tx_serialiser

Overview:
- Downstream consumer of the 8-entry byte FIFO in the UART transmit path.
- Pops one word per frame through the FIFO's valid/consume-strobe interface.
- Serialises each word onto a single TX line: start bit, data LSB-first, optional parity bit, stop bit(s).
- Bit timing comes from a runtime divisor supplied by the APB register block.

Parameters:
- DWIDTH, 8: data bits per frame; must equal the FIFO's DWIDTH.
- DIV_WIDTH, 16: width of the bit-period divisor.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- fifo_data  in  DWIDTH  FIFO data_out; held stable while fifo_valid=1 and no consume.
- fifo_valid  in  1  FIFO data_out_valid.
- fifo_consume  out  1  FIFO data_out_consume_strobe; one-cycle pulse per word taken.
- tx_enable  in  1  permit starting new frames.
- clk_div  in  DIV_WIDTH  bit period minus one, in clk cycles.
- tx  out  1  serial output; idle/mark = 1.
- busy  out  1  frame in progress.

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, fifo_consume=0, state=IDLE, counters=0.
- Reset asserted mid-frame forces tx=1 immediately and abandons the frame. The popped word is lost; no re-pop occurs.
- States and flow: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
- Bit period: clk_div+1 cycles. clk_div=0 gives 1 cycle/bit.
  - clk_div is latched at the pop cycle.
  - Changes mid-frame do not affect the current frame.
- Pop condition: fifo_consume = tx_enable & fifo_valid & (state==IDLE | last cycle of last stop bit).
  - fifo_consume is combinational. It must never be asserted while fifo_valid=0.
- On a pop cycle N:
  - fifo_data is latched into the shift register and parity is computed from it.
  - state becomes START at N+1.
  - tx is registered and goes 0 at N+1.
- START: tx=0 for one bit period.
- DATA: DWIDTH bit periods, LSB first, shifted right at each bit boundary.
- PARITY (only when PARITY!=0): one bit period.
  - Even: parity bit = XOR of the data bits.
  - Odd: parity bit = the inverse of that XOR.
- STOP: tx=1 for STOP_BITS bit periods.
- Back-to-back frames: a pop in the final stop cycle goes straight to START with no idle gap. Frame length is exactly (1+DWIDTH+P+STOP_BITS)*(clk_div+1) cycles, where P=1 if PARITY!=0, else 0.
- If no pop occurs in the final stop cycle, go to IDLE with tx=1.
- busy: 1 from N+1 through the final stop cycle; 0 in IDLE.
- tx_enable=0 mid-frame: the current frame completes and no new pop occurs. Re-enabling in IDLE with fifo_valid=1 pops on that same cycle.
- fifo_valid dropping while not popping: no effect.
- The bit counter uses a $clog2(DWIDTH+1)-bit count. The divisor counter is DIV_WIDTH bits, counts down from the latched clk_div, and never wraps.

Decomposition:
- Shared package uart_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP);
  - PARITY constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2).
- One sub-module, uart_tx_bit_timer:
  - loads the divisor on a start pulse;
  - emits a one-cycle bit_end pulse every clk_div+1 cycles while running.
- The top level contains the FSM, shift register, parity logic and consume logic.

Test Plan:
- 8N1, clk_div=3, one word 0xA5 -> consume pulse at cycle N; tx from N+1, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1; busy high for exactly 40 cycles; then IDLE with tx=1.
- Back-to-back 0x00 then 0xFF, clk_div=0 -> second consume in the last stop cycle of frame 1; total 20 cycles with no idle gap; tx = 0,00000000,1,0,11111111,1.
- PARITY=2 (odd), data 0x07, clk_div=1 -> parity bit = 0 (three 1s); frame length 22 cycles.
- tx_enable dropped at mid-DATA with 2 words queued -> current frame completes, no further consume; re-enable -> pop on that same cycle.
- reset asserted during DATA with clk held -> tx=1, busy=0 without a clock edge; after release and fifo_valid=1 -> fresh frame starting with a start bit.
- clk_div changed from 3 to 7 mid-frame -> the current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared transmit-state encoding and parity-mode constants.
//   Used by uart_tx_serialiser (FSM) and uart_tx_bit_timer.
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: bit-period timer for the UART transmitter.
//   clk     in   system clock
//   reset   in   asynchronous active-low reset
//   start   in   load divisor (pop cycle); restarts the period
//   run     in   frame in progress
//   div     in   bit period minus one, sampled only on start
//   bit_end out  one-cycle pulse in the last cycle of each bit period
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_end
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end
  // Counts down to zero and reloads from the latched divisor, so it never wraps
  // and mid-frame changes on div are invisible until the next start.
  always_comb begin
    div_d   = start ? div : div_q;
    cnt_d   = start ? div : !run ? cnt_q : cnt_q == '0 ? div_q : cnt_q - DIV_WIDTH'(1);
    bit_end = run && cnt_q == '0;
  end
endmodule

// File: rtl/uart_tx_serialiser.sv
// uart_tx_serialiser: pops bytes from the TX FIFO and serialises them as UART frames.
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   fifo_data    in   FIFO head word
//   fifo_valid   in   FIFO head valid
//   fifo_consume out  one-cycle pop strobe (combinational)
//   tx_enable    in   allow new frames to start
//   clk_div      in   bit period minus one, latched at each pop
//   tx           out  serial line, idle high
//   busy         out  frame in progress
module uart_tx_serialiser
  import uart_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int DIV_WIDTH = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DWIDTH-1:0]    fifo_data,
  input  logic                 fifo_valid,
  output logic                 fifo_consume,
  input  logic                 tx_enable,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic                 tx,
  output logic                 busy
);
  localparam int CW = $clog2(DWIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DWIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  tx_state_e         state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              par_q, par_d, tx_q, tx_d;
  logic              bit_end, frame_end, pop;
  uart_tx_bit_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (pop),
    .run    (state_q != ST_IDLE),
    .div    (clk_div),
    .bit_end(bit_end)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    if (pop) begin
      state_d   = ST_START;
      bit_cnt_d = '0;
      shift_d   = fifo_data;
      par_d     = ^fifo_data ^ (PARITY == PAR_ODD);
    end else if (bit_end) begin
      case (state_q)
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q == LAST_DATA ? '0 : bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_DATA) state_d = PARITY != PAR_NONE ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: state_d = ST_STOP;
        ST_STOP: begin
          bit_cnt_d = frame_end ? '0 : bit_cnt_q + CW'(1);
          if (frame_end) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // tx is registered from the next state so it changes together with the state.
    tx_d = state_d == ST_START ? 1'b0 : state_d == ST_DATA ? shift_d[0] :
           state_d == ST_PARITY ? par_d : 1'b1;
  end
  always_comb begin
    frame_end    = state_q == ST_STOP && bit_end && bit_cnt_q == LAST_STOP;
    pop          = reset && tx_enable && fifo_valid && (state_q == ST_IDLE || frame_end);
    fifo_consume = pop;
    tx           = tx_q;
    busy         = state_q != ST_IDLE;
  end
endmodule

// File: tb/tb_uart_tx_serialiser.sv
// tb_uart_tx_serialiser: checks three configurations (8N1, 8O1, 8E2) against a frame-level model.
module tb_uart_tx_serialiser;
  localparam int NI = 3;
  logic clk = 1'b0, reset_n = 1'b1, tx_en = 1'b0;
  logic [15:0] div = '0;
  logic [7:0] fd [NI];
  logic [NI-1:0] fv, fc, txo, bsy, vmask;
  logic [NI-1:0] s_tx, s_busy, s_c;
  logic [7:0] fmem [NI][64];
  int rd [NI], wr [NI];
  logic m_act [NI];
  int m_pos [NI], m_per [NI], m_len [NI];
  logic [11:0] m_bits [NI];
  logic e_c [NI];
  int nvec = 0, nmis = 0;

  always #5 clk = ~clk;

  uart_tx_serialiser #(.PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .reset(reset_n), .fifo_data(fd[0]),
    .fifo_valid(fv[0]), .fifo_consume(fc[0]), .tx_enable(tx_en), .clk_div(div), .tx(txo[0]), .busy(bsy[0]));
  uart_tx_serialiser #(.PARITY(2), .STOP_BITS(1)) dut1 (.clk(clk), .reset(reset_n), .fifo_data(fd[1]),
    .fifo_valid(fv[1]), .fifo_consume(fc[1]), .tx_enable(tx_en), .clk_div(div), .tx(txo[1]), .busy(bsy[1]));
  uart_tx_serialiser #(.PARITY(1), .STOP_BITS(2)) dut2 (.clk(clk), .reset(reset_n), .fifo_data(fd[2]),
    .fifo_valid(fv[2]), .fifo_consume(fc[2]), .tx_enable(tx_en), .clk_div(div), .tx(txo[2]), .busy(bsy[2]));

  function automatic int par_of(int i);
    return i == 1 ? 2 : i == 2 ? 1 : 0;
  endfunction
  function automatic int stp_of(int i);
    return i == 2 ? 2 : 1;
  endfunction
  function automatic int nbits(int i);
    return 9 + (par_of(i) != 0 ? 1 : 0) + stp_of(i);
  endfunction
  // Bit k of the result is the k-th bit on the line.
  function automatic logic [11:0] frame(int i, logic [7:0] d);
    logic [11:0] b = '0;
    int p = 9;
    for (int k = 0; k < 8; k++) b[1+k] = d[k];
    if (par_of(i) != 0) begin
      b[p] = (^d) ^ (par_of(i) == 2);
      p++;
    end
    for (int s = 0; s < stp_of(i); s++) b[p+s] = 1'b1;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      fd[i] = fmem[i][rd[i] % 64];
      fv[i] = wr[i] != rd[i] && vmask[i];
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    fmem[i][wr[i] % 64] = d;
    wr[i]++;
    drive();
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) m_act[i] = 1'b0;
      e_c[i] = reset_n && tx_en && fv[i] && (!m_act[i] || m_pos[i] == m_len[i] - 1);
      chk($sformatf("tx%0d", i), txo[i], m_act[i] ? m_bits[i][m_pos[i] / m_per[i]] : 1'b1);
      chk($sformatf("busy%0d", i), bsy[i], m_act[i]);
      chk($sformatf("consume%0d", i), fc[i], e_c[i]);
    end
    s_tx = txo;
    s_busy = bsy;
    s_c = fc;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (e_c[i]) begin
        m_bits[i] = frame(i, fd[i]);
        m_per[i] = int'(div) + 1;
        m_len[i] = nbits(i) * m_per[i];
        m_pos[i] = 0;
        m_act[i] = 1'b1;
        rd[i]++;
      end else if (m_act[i]) begin
        m_pos[i]++;
        if (m_pos[i] == m_len[i]) m_act[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic capture(input int i, input int lim, output int cnt, output logic [127:0] seq, output int pops);
    cnt = 0;
    seq = '0;
    pops = 0;
    for (int t = 0; t < lim; t++) begin
      tick();
      pops += int'(s_c[i]);
      if (s_busy[i]) begin
        if (cnt < 128) seq[cnt] = s_tx[i];
        cnt++;
      end else if (cnt > 0) break;
    end
  endtask

  task automatic run_frame(input int i, input logic [7:0] d, input int dv, output int cnt, output logic [11:0] bits);
    logic [127:0] seq;
    int pops;
    div = 16'(dv);
    tx_en = 1'b1;
    push(i, d);
    capture(i, 400, cnt, seq, pops);
    bits = '0;
    for (int k = 0; k < nbits(i); k++) bits[k] = seq[k*(dv+1)];
  endtask

  typedef struct {
    int inst;
    logic [7:0] data;
    int dv;
    logic [11:0] bits;
    int len;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int cnt, pops, lvl;
    logic [127:0] seq;
    logic [11:0] bits;
    tbl[0] = '{0, 8'hA5, 3, {2'b00, 1'b1, 8'hA5, 1'b0}, 40};
    tbl[1] = '{1, 8'h07, 1, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 22};
    tbl[2] = '{2, 8'h07, 2, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 36};
    tbl[3] = '{0, 8'h00, 0, {2'b00, 1'b1, 8'h00, 1'b0}, 10};
    tbl[4] = '{1, 8'hFF, 0, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11};
    tbl[5] = '{2, 8'h80, 4, {1'b1, 1'b1, 1'b1, 8'h80, 1'b0}, 60};
    tbl[6] = '{1, 8'h00, 2, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 33};
    vmask = '1;
    for (int i = 0; i < NI; i++) begin
      rd[i] = 0;
      wr[i] = 0;
      m_act[i] = 1'b0;
      m_pos[i] = 0;
      m_per[i] = 1;
      m_len[i] = 1;
      m_bits[i] = '0;
    end
    drive();
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 7; v++) begin
      run_frame(tbl[v].inst, tbl[v].data, tbl[v].dv, cnt, bits);
      chk($sformatf("tbl%0d_len", v), cnt, tbl[v].len);
      chk($sformatf("tbl%0d_bits", v), bits, tbl[v].bits);
    end

    div = 16'd0;
    push(0, 8'h00);
    push(0, 8'hFF);
    capture(0, 100, cnt, seq, pops);
    chk("b2b_len", cnt, 20);
    chk("b2b_tx", seq, {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0});
    chk("b2b_pops", pops, 2);

    div = 16'd1;
    push(0, 8'h5A);
    push(0, 8'h11);
    push(0, 8'h22);
    repeat (8) tick();
    tx_en = 1'b0;
    capture(0, 100, cnt, seq, pops);
    lvl = wr[0] - rd[0];
    chk("en_off_pops", pops, 0);
    chk("en_off_level", lvl, 2);
    repeat (4) tick();
    tx_en = 1'b1;
    tick();
    chk("reen_pop", s_c[0], 1'b1);
    capture(0, 200, cnt, seq, pops);
    chk("reen_len", cnt, 40);

    div = 16'd3;
    push(0, 8'hC3);
    repeat (12) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_tx", txo[0], 1'b1);
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_consume", fc[0], 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_frame(0, 8'h3C, 1, cnt, bits);
    chk("post_rst_len", cnt, 20);
    chk("post_rst_bits", bits, {2'b00, 1'b1, 8'h3C, 1'b0});

    div = 16'd3;
    push(0, 8'h96);
    push(0, 8'h69);
    repeat (6) tick();
    div = 16'd7;
    capture(0, 300, cnt, seq, pops);
    chk("div_len", cnt, 35 + 80);
    chk("div_start2", seq[42:35], 8'h00);
    chk("div_d0", seq[43], 1'b1);
    chk("div_pops", pops, 1);

    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        int i = int'($urandom_range(0, NI - 1));
        if (wr[i] - rd[i] < 60) push(i, 8'($urandom));
      end
      if ($urandom_range(0, 49) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 99) == 0) div = 16'($urandom_range(0, 3));
      vmask = $urandom_range(0, 3) == 0 ? NI'($urandom) : '1;
      drive();
      tick();
    end
    tx_en = 1'b1;
    vmask = '1;
    drive();
    for (int t = 0; t < 20000; t++) begin
      tick();
      lvl = 0;
      for (int i = 0; i < NI; i++) lvl += (wr[i] - rd[i]) + int'(m_act[i]);
      if (lvl == 0) break;
    end
    chk("drain", lvl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
